// File: rtl/onchip_rom_arb.sv
// onchip_rom_arb: two-master round-robin arbiter in front of a synchronous
// single-port ROM.
//
// One access is three clocks: IDLE (grant, latch address) -> ADDR (ROM samples
// rom_address) -> DATA (rom_q valid, captured on the DATA->IDLE edge, where the
// master's ack goes high for one cycle).
//
// Handshake: a master raises mX_rd_ena with a stable mX_address and holds both
// until it sees mX_data_ack high for one cycle. In that same cycle mX_rd_data
// is valid. A request that is still high during the ack cycle is ignored for
// that cycle, so it cannot be serviced a second time by accident.
module onchip_rom_arb #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  m0_rd_ena,
    input  logic [ADDR_WIDTH-2:0] m0_address,
    output logic [15:0]           m0_rd_data,
    output logic                  m0_data_ack,
    input  logic                  m1_rd_ena,
    input  logic [ADDR_WIDTH-2:0] m1_address,
    output logic [15:0]           m1_rd_data,
    output logic                  m1_data_ack,
    output logic [ADDR_WIDTH-2:0] rom_address,
    input  logic [15:0]           rom_q,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Index of the master granted most recently (round-robin pointer).
    logic last_grant;
    // Index of the master that owns the access in flight.
    logic grant_q;

    logic req0;
    logic req1;
    logic grant_fire;
    logic grant_sel;

    // Mask each request during its own ack cycle, then pick a winner.
    always_comb begin
        req0       = m0_rd_ena & ~m0_data_ack;
        req1       = m1_rd_ena & ~m1_data_ack;
        grant_fire = (state_q == IDLE) && (req0 || req1);
        grant_sel  = 1'b0;
        if (req0 && req1) begin
            grant_sel = ~last_grant;
        end else if (req1) begin
            grant_sel = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: only IDLE waits; ADDR and DATA each last one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = grant_fire ? ADDR : IDLE;
            ADDR:    state_d = DATA;
            DATA:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic from state.
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Datapath: latch address and owner at grant, return data and ack at end.
    always_ff @(posedge clock) begin
        if (reset) begin
            rom_address <= '0;
            last_grant  <= 1'b1;
            grant_q     <= 1'b0;
            m0_rd_data  <= 16'h0000;
            m1_rd_data  <= 16'h0000;
            m0_data_ack <= 1'b0;
            m1_data_ack <= 1'b0;
        end else begin
            m0_data_ack <= 1'b0;
            m1_data_ack <= 1'b0;
            if (grant_fire) begin
                rom_address <= grant_sel ? m1_address : m0_address;
                last_grant  <= grant_sel;
                grant_q     <= grant_sel;
            end
            if (state_q == DATA) begin
                if (grant_q) begin
                    m1_rd_data  <= rom_q;
                    m1_data_ack <= 1'b1;
                end else begin
                    m0_rd_data  <= rom_q;
                    m0_data_ack <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_onchip_rom_arb.sv
// Testbench for onchip_rom_arb: directed vectors, scoreboard of expected
// {master, data} completions, and a monitor that checks every ack.
module tb_onchip_rom_arb;

    localparam int AW = 12;

    logic          clock;
    logic          reset;
    logic          m0_rd_ena;
    logic [AW-2:0] m0_address;
    logic [15:0]   m0_rd_data;
    logic          m0_data_ack;
    logic          m1_rd_ena;
    logic [AW-2:0] m1_address;
    logic [15:0]   m1_rd_data;
    logic          m1_data_ack;
    logic [AW-2:0] rom_address;
    logic [15:0]   rom_q;
    logic          busy;

    logic [15:0]   mem [0:(1<<(AW-1))-1];
    logic [16:0]   exp_q [$];
    int            vectors;
    int            fails;
    logic          hold0;
    logic          hold1;

    onchip_rom_arb #(.ADDR_WIDTH(AW)) dut (
        .clock       (clock),
        .reset       (reset),
        .m0_rd_ena   (m0_rd_ena),
        .m0_address  (m0_address),
        .m0_rd_data  (m0_rd_data),
        .m0_data_ack (m0_data_ack),
        .m1_rd_ena   (m1_rd_ena),
        .m1_address  (m1_address),
        .m1_rd_data  (m1_rd_data),
        .m1_data_ack (m1_data_ack),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .busy        (busy)
    );

    // Clock and watchdog
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Synchronous ROM model: data valid one clock after the address is sampled
    always @(posedge clock) rom_q <= mem[rom_address];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock: advance past the edge, then let masters drop requests on ack
    task automatic step();
        @(posedge clock);
        #1;
        if (m0_data_ack && !hold0) m0_rd_ena = 1'b0;
        if (m1_data_ack && !hold1) m1_rd_ena = 1'b0;
    endtask

    // Monitor: every ack must match the head of the expected queue
    always @(negedge clock) begin
        if (!reset) begin
            if (m0_data_ack && m1_data_ack) begin
                check("both_acks", 32'd1, 32'd0);
            end
            if (m0_data_ack) begin
                if (exp_q.size() == 0) check("m0_unexpected_ack", 32'd1, 32'd0);
                else check("m0_ack_data", {15'd0, 1'b0, m0_rd_data}, {15'd0, exp_q.pop_front()});
            end
            if (m1_data_ack) begin
                if (exp_q.size() == 0) check("m1_unexpected_ack", 32'd1, 32'd0);
                else check("m1_ack_data", {15'd0, 1'b1, m1_rd_data}, {15'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        vectors = 0;
        fails   = 0;
        hold0   = 1'b0;
        hold1   = 1'b0;
        for (int i = 0; i < (1 << (AW - 1)); i++) mem[i] = 16'h0000;
        mem[11'h001] = 16'h1111;
        mem[11'h002] = 16'h2222;
        mem[11'h010] = 16'hABCD;
        mem[11'h020] = 16'h5A5A;
        mem[11'h030] = 16'h3030;
        mem[11'h031] = 16'h3131;
        mem[11'h040] = 16'h4040;
        mem[11'h050] = 16'h5050;
        mem[11'h060] = 16'h6060;
        mem[11'h070] = 16'h7070;
        reset      = 1'b1;
        m0_rd_ena  = 1'b0;
        m1_rd_ena  = 1'b0;
        m0_address = '0;
        m1_address = '0;

        // Reset state
        step(); step(); step();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ack0", {31'd0, m0_data_ack}, 32'd0);
        check("rst_ack1", {31'd0, m1_data_ack}, 32'd0);
        check("rst_rom_address", {21'd0, rom_address}, 32'd0);
        check("rst_rd0", {16'd0, m0_rd_data}, 32'd0);
        check("rst_rd1", {16'd0, m1_rd_data}, 32'd0);
        reset = 1'b0;

        // Contention after reset: m0 first, m1 three cycles later
        m0_address = 11'h001; m0_rd_ena = 1'b1;
        m1_address = 11'h002; m1_rd_ena = 1'b1;
        exp_q.push_back({1'b0, 16'h1111});
        exp_q.push_back({1'b1, 16'h2222});
        step();
        check("cont_busy", {31'd0, busy}, 32'd1);
        check("cont_addr0", {21'd0, rom_address}, 32'h001);
        step(); step();
        check("cont_ack0", {31'd0, m0_data_ack}, 32'd1);
        check("cont_ack1_low", {31'd0, m1_data_ack}, 32'd0);
        check("cont_rd0", {16'd0, m0_rd_data}, 32'h1111);
        step();
        check("cont_addr1", {21'd0, rom_address}, 32'h002);
        step(); step();
        check("cont_ack1", {31'd0, m1_data_ack}, 32'd1);
        check("cont_ack0_low", {31'd0, m0_data_ack}, 32'd0);
        check("cont_rd1", {16'd0, m1_rd_data}, 32'h2222);
        step();
        check("idle_hold_addr", {21'd0, rom_address}, 32'h002);
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Single read with latency and busy duration
        m0_address = 11'h010; m0_rd_ena = 1'b1;
        exp_q.push_back({1'b0, 16'hABCD});
        step();
        check("single_busy1", {31'd0, busy}, 32'd1);
        check("single_addr", {21'd0, rom_address}, 32'h010);
        step();
        check("single_busy2", {31'd0, busy}, 32'd1);
        check("single_early_ack", {31'd0, m0_data_ack}, 32'd0);
        step();
        check("single_ack", {31'd0, m0_data_ack}, 32'd1);
        check("single_data", {16'd0, m0_rd_data}, 32'hABCD);
        check("single_busy3", {31'd0, busy}, 32'd0);
        step();

        // Address change after grant has no effect
        m0_address = 11'h010; m0_rd_ena = 1'b1;
        exp_q.push_back({1'b0, 16'hABCD});
        step();
        m0_address = 11'h020;
        step(); step();
        check("addrchg_ack", {31'd0, m0_data_ack}, 32'd1);
        check("addrchg_data", {16'd0, m0_rd_data}, 32'hABCD);
        step();

        // Fairness: last grant was m0, so m1 wins first, then alternate
        hold0 = 1'b1; hold1 = 1'b1;
        m0_address = 11'h030; m0_rd_ena = 1'b1;
        m1_address = 11'h031; m1_rd_ena = 1'b1;
        exp_q.push_back({1'b1, 16'h3131});
        exp_q.push_back({1'b0, 16'h3030});
        exp_q.push_back({1'b1, 16'h3131});
        exp_q.push_back({1'b0, 16'h3030});
        for (int i = 1; i <= 12; i++) begin
            step();
            check($sformatf("fair_ack1_c%0d", i), {31'd0, m1_data_ack}, (i == 3 || i == 9) ? 32'd1 : 32'd0);
            check($sformatf("fair_ack0_c%0d", i), {31'd0, m0_data_ack}, (i == 6 || i == 12) ? 32'd1 : 32'd0);
        end
        hold0 = 1'b0; hold1 = 1'b0;
        m0_rd_ena = 1'b0; m1_rd_ena = 1'b0;
        step();
        check("fair_idle", {31'd0, busy}, 32'd0);

        // Ack masking: request held through ack restarts one cycle later
        hold1 = 1'b1;
        m1_address = 11'h040; m1_rd_ena = 1'b1;
        exp_q.push_back({1'b1, 16'h4040});
        exp_q.push_back({1'b1, 16'h4040});
        step(); step(); step();
        check("mask_ack", {31'd0, m1_data_ack}, 32'd1);
        step();
        check("mask_no_grant_in_ack", {31'd0, busy}, 32'd0);
        step();
        check("mask_regrant", {31'd0, busy}, 32'd1);
        hold1 = 1'b0;
        step(); step();
        check("mask_ack2", {31'd0, m1_data_ack}, 32'd1);
        step();
        check("mask_done1", {31'd0, busy}, 32'd0);
        step();
        check("mask_done2", {31'd0, busy}, 32'd0);

        // Request dropped before grant is never serviced
        m1_address = 11'h060; m1_rd_ena = 1'b1;
        exp_q.push_back({1'b1, 16'h6060});
        step();
        m0_address = 11'h070; m0_rd_ena = 1'b1;
        step();
        m0_rd_ena = 1'b0;
        step();
        check("drop_ack1", {31'd0, m1_data_ack}, 32'd1);
        step();
        check("drop_idle1", {31'd0, busy}, 32'd0);
        step();
        check("drop_idle2", {31'd0, busy}, 32'd0);

        // Reset in DATA aborts; pending m1 request served after release
        m1_address = 11'h050; m1_rd_ena = 1'b1;
        step(); step();
        reset = 1'b1;
        step();
        check("rmid_busy", {31'd0, busy}, 32'd0);
        check("rmid_ack0", {31'd0, m0_data_ack}, 32'd0);
        check("rmid_ack1", {31'd0, m1_data_ack}, 32'd0);
        check("rmid_addr", {21'd0, rom_address}, 32'd0);
        check("rmid_rd0", {16'd0, m0_rd_data}, 32'd0);
        check("rmid_rd1", {16'd0, m1_rd_data}, 32'd0);
        reset = 1'b0;
        exp_q.push_back({1'b1, 16'h5050});
        step();
        check("rmid_regrant", {21'd0, rom_address}, 32'h050);
        step(); step();
        check("rmid_ack", {31'd0, m1_data_ack}, 32'd1);
        check("rmid_data", {16'd0, m1_rd_data}, 32'h5050);
        step(); step();

        check("exp_q_empty", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
